// File: rtl/seg_scan_1khz.sv
// Four-digit seven-segment scanner driven by an external 1 kHz square wave.
// tick_src is treated purely as data: it is synchronized into clk_in, its
// rising edge becomes a registered single-cycle tick, and each tick advances
// the scan one digit. Display inputs are captured into a shadow register once
// per frame, so one frame never mixes old and new values.
//
// Handshake note: there is no valid/ready pairing on this block. The display
// inputs are sampled only at frame wrap. The outputs are registered and only
// change on the clk_in edge that follows a tick.
module seg_scan_1khz #(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        tick_src,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_en,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    // Out-of-range synchronizer depths are clamped into the legal 2..3 window.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : ((SYNC_STAGES > 3) ? 3 : SYNC_STAGES);

    // These are the "unlit" levels for the chosen output polarity.
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1  : 1'b0;

    logic [STAGES-1:0] sync_q;
    logic              edge_q;
    logic              tick_q;

    logic [1:0]        idx_q;
    logic [15:0]       sh_digits_q;
    logic [3:0]        sh_dp_q;
    logic              sh_lz_q;

    logic              wrap;
    logic [1:0]        idx_nxt;
    logic [15:0]       use_digits;
    logic [3:0]        use_dp;
    logic              use_lz;
    logic [3:0]        nibble;
    logic              blank;
    logic [6:0]        seg_al;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic [3:0]        an_nxt;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg_al(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Synchronize tick_src and register its rising edge as a one-cycle tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], tick_src};
            edge_q <= sync_q[STAGES-1];
            tick_q <= sync_q[STAGES-1] & ~edge_q;
        end
    end

    // Work out the next digit. At wrap, decode from the live inputs because
    // those are the values being captured into the shadow on the same edge.
    always_comb begin
        wrap       = (idx_q == 2'd3);
        idx_nxt    = idx_q + 2'd1;
        use_digits = wrap ? digits   : sh_digits_q;
        use_dp     = wrap ? dp_en    : sh_dp_q;
        use_lz     = wrap ? lz_blank : sh_lz_q;

        nibble = 4'h0;
        blank  = 1'b0;
        case (idx_nxt)
            2'd0: begin
                nibble = use_digits[3:0];
                blank  = 1'b0;
            end
            2'd1: begin
                nibble = use_digits[7:4];
                blank  = use_lz && (use_digits[15:4] == 12'h000);
            end
            2'd2: begin
                nibble = use_digits[11:8];
                blank  = use_lz && (use_digits[15:8] == 8'h00);
            end
            default: begin
                nibble = use_digits[15:12];
                blank  = use_lz && (use_digits[15:12] == 4'h0);
            end
        endcase

        seg_al = blank ? 7'h7F : hex_to_seg_al(nibble);
        seg_nxt = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
        dp_nxt  = use_dp[idx_nxt] ? ~DP_OFF : DP_OFF;
        an_nxt  = ~(4'b0001 << idx_nxt);
    end

    // Advance the scan, capture the shadow at wrap, and register the outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= 2'd3;
            sh_digits_q <= 16'h0000;
            sh_dp_q     <= 4'h0;
            sh_lz_q     <= 1'b0;
            an          <= 4'hF;
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= tick_q & wrap;
            if (tick_q) begin
                idx_q <= idx_nxt;
                an    <= an_nxt;
                seg   <= seg_nxt;
                dp    <= dp_nxt;
                if (wrap) begin
                    sh_digits_q <= digits;
                    sh_dp_q     <= dp_en;
                    sh_lz_q     <= lz_blank;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_1khz.sv
// Bench for seg_scan_1khz. It runs directed scenarios and then randomized
// frames, and compares every result against a frame-level reference model.
module tb_seg_scan_1khz;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        tick_src;
    logic [15:0] digits;
    logic [3:0]  dp_en;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int passes = 0;
    int total  = 0;

    // Reference model state: the digit currently shown and the frame shadow.
    int          m_idx;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic        m_lz;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // clock / reset
    always #5 clk_in = ~clk_in;

    seg_scan_1khz #(.SEG_ACTIVE_LOW(1), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .tick_src(tick_src), .digits(digits),
        .dp_en(dp_en), .lz_blank(lz_blank), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [6:0] exp_seg();
        logic [15:0] upper;
        upper = m_digits >> (4 * m_idx);
        if (m_lz && m_idx > 0 && upper == 16'h0) return 7'h7F;
        return hex_tab[upper[3:0]];
    endfunction

    task automatic model_reset();
        m_idx = 3; m_digits = '0; m_dp = '0; m_lz = 1'b0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ":an"},  {12'h0, an},  {12'h0, ~(4'b0001 << m_idx)});
        chk({tag, ":seg"}, {9'h0, seg},  {9'h0, exp_seg()});
        chk({tag, ":dp"},  {15'h0, dp},  {15'h0, ~m_dp[m_idx]});
    endtask

    // Driver: one rising edge on tick_src. Outputs must hold for three
    // clk_in edges, change on the fourth, and then hold through the fall.
    task automatic pulse(input string tag);
        logic [3:0] an_before;
        logic [6:0] seg_before;
        bit         wraps;
        an_before  = an;
        seg_before = seg;
        @(negedge clk_in) tick_src = 1'b1;
        repeat (3) @(negedge clk_in);
        chk({tag, ":hold_an"},  {12'h0, an},  {12'h0, an_before});
        chk({tag, ":hold_seg"}, {9'h0, seg},  {9'h0, seg_before});
        @(negedge clk_in);
        m_idx = (m_idx + 1) % 4;
        wraps = (m_idx == 0);
        if (wraps) begin
            m_digits = digits; m_dp = dp_en; m_lz = lz_blank;
        end
        chk_outputs(tag);
        chk({tag, ":frame_done"}, {15'h0, frame_done}, {15'h0, wraps});
        @(negedge clk_in);
        chk({tag, ":frame_done_1cyc"}, {15'h0, frame_done}, 16'h0);
        tick_src = 1'b0;
        repeat (5) @(negedge clk_in);
        chk({tag, ":fall_no_tick"}, {12'h0, an}, {12'h0, ~(4'b0001 << m_idx)});
    endtask

    initial begin
        rst_n = 1'b0; tick_src = 1'b0; digits = '0; dp_en = '0; lz_blank = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("rst:an", {12'h0, an}, 16'h000F);
        chk("rst:seg", {9'h0, seg}, 16'h007F);
        chk("rst:dp", {15'h0, dp}, 16'h0001);
        chk("rst:frame_done", {15'h0, frame_done}, 16'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_in);
        chk("post_rst_hold:an", {12'h0, an}, 16'h000F);

        // Four ticks across 1234: digit 0 shows "4", then 3, 2, 1.
        digits = 16'h1234; dp_en = 4'b0000; lz_blank = 1'b0;
        pulse("h1234_d0"); chk("h1234_d0_seg", {9'h0, seg}, {9'h0, 7'b0011001});
        pulse("h1234_d1"); chk("h1234_d1_seg", {9'h0, seg}, {9'h0, 7'b0110000});
        pulse("h1234_d2"); chk("h1234_d2_seg", {9'h0, seg}, {9'h0, 7'b0100100});
        pulse("h1234_d3"); chk("h1234_d3_seg", {9'h0, seg}, {9'h0, 7'b1111001});

        // Leading-zero blanking on 0070.
        digits = 16'h0070; lz_blank = 1'b1;
        pulse("lz_d0"); chk("lz_d0_seg", {9'h0, seg}, {9'h0, 7'b1000000});
        pulse("lz_d1"); chk("lz_d1_seg", {9'h0, seg}, {9'h0, 7'b1111000});
        pulse("lz_d2"); chk("lz_d2_seg", {9'h0, seg}, 16'h007F);
        pulse("lz_d3"); chk("lz_d3_seg", {9'h0, seg}, 16'h007F);

        // Shadow capture: change inputs mid-frame, with dp on digit 2.
        digits = 16'hAAAA; lz_blank = 1'b0; dp_en = 4'b0100;
        pulse("aa_d0");
        pulse("aa_d1");
        digits = 16'h5555;
        pulse("aa_d2"); chk("aa_d2_seg", {9'h0, seg}, {9'h0, 7'b0001000});
        chk("aa_d2_dp", {15'h0, dp}, 16'h0);
        pulse("aa_d3"); chk("aa_d3_seg", {9'h0, seg}, {9'h0, 7'b0001000});
        chk("aa_d3_dp", {15'h0, dp}, 16'h1);
        pulse("ff_d0"); chk("ff_d0_seg", {9'h0, seg}, {9'h0, 7'b0010010});
        chk("ff_d0_dp", {15'h0, dp}, 16'h1);
        pulse("ff_d1");
        pulse("ff_d2"); chk("ff_d2_an", {12'h0, an}, 16'h000B);

        // Asynchronous reset while an=1011, asserted away from any clock edge.
        @(negedge clk_in); #2;
        rst_n = 1'b0; #1;
        chk("async_rst:an", {12'h0, an}, 16'h000F);
        chk("async_rst:seg", {9'h0, seg}, 16'h007F);
        chk("async_rst:dp", {15'h0, dp}, 16'h0001);
        model_reset();
        @(negedge clk_in) rst_n = 1'b1;
        digits = 16'h0000; dp_en = 4'h0; lz_blank = 1'b0;
        pulse("after_rst"); chk("after_rst_an", {12'h0, an}, 16'h000E);

        // Randomized frames with inputs changing at arbitrary digits.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) digits = 16'($urandom);
            if ($urandom_range(0, 2) == 0) digits = {$urandom_range(0, 1) ? 8'h00 : 8'($urandom), 8'($urandom)};
            dp_en    = 4'($urandom);
            lz_blank = 1'($urandom);
            pulse($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_1khz.md
SEG_SCAN_1KHZ -- requirements
Module: seg_scan_1khz

Interface
REQ-001 Parameter: SEG_ACTIVE_LOW, default 1, meaning 1 = segment and decimal-point outputs are driven low to light.
REQ-002 Parameter: SYNC_STAGES, default 2, meaning the number of synchronizer flops on tick_src (legal values 2..3).
REQ-003 Port: clk_in  input  1  system clock, the same clock that drives the 1 kHz divider.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: tick_src  input  1  1 kHz square wave from the divider's clk_out; treated as data, never as a clock.
REQ-006 Port: digits  input  16  four 4-bit hex values; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 Port: dp_en  input  4  decimal-point enable per digit, with bit i belonging to digit i.
REQ-008 Port: lz_blank  input  1  1 = blank leading zeros.
REQ-009 Port: an  output  4  digit select, active-low, one-hot-low while scanning.
REQ-010 Port: seg  output  7  segment bits {g,f,e,d,c,b,a}.
REQ-011 Port: dp  output  1  decimal point.
REQ-012 Port: frame_done  output  1  one-cycle pulse when digit 3 has been displayed and the scan wraps to digit 0.

Function
REQ-013 tick_src SHALL pass through SYNC_STAGES flops and then a rising-edge detector, producing tick as a single-cycle pulse.
REQ-014 With SYNC_STAGES=2, tick SHALL assert on the 3rd clk_in rising edge after tick_src rises; a falling edge of tick_src SHALL NOT produce a tick.
REQ-015 A 2-bit index idx SHALL advance on each tick in the order 0->1->2->3->0, wrapping with no gap.
REQ-016 On each tick where idx wraps 3->0, and on the first tick after reset, digits, dp_en and lz_blank SHALL be captured into a shadow register; all display decode SHALL use the shadow only (no tearing within a frame).
REQ-017 an, seg and dp SHALL be registered and SHALL update on the clk_in edge following tick (1-cycle latency from tick), all in the same cycle.
REQ-018 an SHALL drive exactly one bit low, bit idx; no cycle SHALL exist in which two bits of an are low.
REQ-019 Hex decode with SEG_ACTIVE_LOW=1 SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 With SEG_ACTIVE_LOW=0, seg and dp SHALL be the bitwise inverse of the active-low values.
REQ-021 Leading-zero blanking: when the shadow lz_blank is 1, digit i (i = 3, 2, 1) SHALL be blanked if it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-022 A blanked digit SHALL drive seg all-off while its an bit is still asserted; its dp SHALL still follow dp_en.
REQ-023 dp SHALL be lit if and only if the shadow dp_en[idx] is 1.
REQ-024 frame_done SHALL pulse in the same cycle that the outputs for the new digit 0 appear.
REQ-025 If tick_src is held constant, all outputs SHALL hold their values indefinitely.
REQ-026 If tick_src toggles faster than clk_in/4, edges may be missed; behaviour SHALL stay legal (one-hot an).

Reset
REQ-027 While rst_n=0 (asynchronous), the module SHALL hold: an=1111, seg=all-off, dp=off, frame_done=0, idx=3, sync flops=0, edge flop=0, shadow=0.
REQ-028 idx SHALL reset to 3 so that the first tick after reset selects digit 0 and pulses frame_done.
REQ-029 After rst_n deasserts, outputs SHALL stay at their reset values until the first tick.
REQ-030 A tick_src edge already in the synchronizer when reset asserts SHALL be discarded.
REQ-031 Reset asserted mid-frame SHALL force the reset values in the same cycle, independent of clk_in.

Verification
REQ-032 Reset, digits=16'h1234, dp_en=0000, lz_blank=0, with 4 tick_src rising edges -> an steps 1110, 1101, 1011, 0111; seg steps 0011001 ("4"), 0110000, 0100100, 1111001.
REQ-033 After one tick_src rising edge -> tick on the 3rd clk_in edge, an/seg change on the 4th, frame_done high for exactly 1 cycle.
REQ-034 digits=16'h0070, lz_blank=1 -> digit 3 off, digit 2 off, digit 1 shows 1111000, digit 0 shows 1000000.
REQ-035 Change digits from 16'hAAAA to 16'h5555 while idx=1 -> digits 2 and 3 still show A (0001000); the next frame shows 5 (0010010).
REQ-036 dp_en=0100 -> dp lit only while an=1011.
REQ-037 Assert rst_n low while an=1011 -> an=1111 immediately, without waiting for clk_in; after release, the first tick gives an=1110.
